traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
//  Sequences the 2-bit StateFlag that drives the maquete decoder (0=principal green, 1=principal yellow,
//  2=secondary green, 3=secondary yellow). Times each phase from a clock prescaler.
//  Serves the secondary road on demand: principal green rests until a secondary vehicle request exists.
//  Sits between board inputs (detector) and the decoder. StateFlag feeds the decoder directly.
// PARAMETERS
//  TICK_DIV   50_000_000  clk cycles per 1 s tick (benches override to 4)
//  T_PG_MIN   20          minimum principal green, ticks (1..255)
//  T_PY       3           principal yellow, ticks (1..255)
//  T_SG       10          secondary green base, ticks (1..255)
//  T_SY       3           secondary yellow, ticks (1..255)
//  T_SG_MAX   20          secondary green ceiling, ticks (>= T_SG; used only with SEC_EXTEND_EN)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  SecReq       in   1  secondary-road vehicle detector, level, pre-synchronised
//  StateFlag    out  2  current phase code, to decoder
//  SecsLeft     out  8  ticks remaining in current phase
//  ReqPending   out  1  latched secondary request
//  PhaseChange  out  1  one-cycle pulse in the first cycle of each new phase
// BEHAVIOUR
//  Reset (async, rst_n=0): StateFlag=0, SecsLeft=T_PG_MIN, ReqPending=0, PhaseChange=0, prescaler=0.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
//   Prescaler clears to 0 on every phase change, so each phase lasts exactly duration*TICK_DIV cycles.
//  Phase entry: SecsLeft loads the phase duration; PhaseChange=1 in that same cycle.
//  On tick with SecsLeft>1: SecsLeft decrements.
//  On tick with SecsLeft==1: the phase ends, subject to the rules below.
//   PG(0): go to PY if ReqPending=1. Otherwise SecsLeft holds at 1 and PG rests.
//    A request arriving during the rest switches the phase at the next tick.
//   PY(1) -> SG(2) -> SY(3) -> PG(0): unconditional.
//  All registered outputs update on the same clk edge; StateFlag has no gap or invalid code.
//  ReqPending:
//   Set on any cycle with SecReq=1 while StateFlag!=2.
//   Cleared in the cycle SG is entered; entry has priority over a simultaneous set.
//   SecReq during SG is ignored and not latched.
//  Codes are always legal: a 2-bit state has no unreachable encodings.
//  rst_n assertion mid-phase returns to PG immediately, with no yellow inserted.
// CONFIGURATION
//  SEC_EXTEND_EN defined:
//   In SG, at SecsLeft==1 on a tick with SecReq=1, SG holds (SecsLeft stays 1).
//   The hold lasts while elapsed SG ticks < T_SG_MAX.
//   An 8-bit elapsed counter clears on SG entry and increments on each SG tick.
//   SG is forced to SY when elapsed reaches T_SG_MAX.
//  SEC_EXTEND_EN undefined: SG lasts exactly T_SG ticks. No elapsed counter is built.
// STRUCTURE
//  Shared package traffic_pkg:
//   phase localparams PH_PG=2'd0, PH_PY=2'd1, PH_SG=2'd2, PH_SY=2'd3 (also used by the decoder);
//   phase width constant PH_W=2; timer width TMR_W=8.
//  Sub-module tick_prescaler (params TICK_DIV; ports clk, rst_n, clr, tick).
//  The FSM and timer stay in this module.
// TESTING (TICK_DIV=4, T_PG_MIN=3, T_PY=2, T_SG=2, T_SY=1, T_SG_MAX=4)
//  1. Release reset with SecReq=0 for 40 cycles.
//     -> StateFlag stays 0; SecsLeft reaches 1 after 8 cycles and holds; PhaseChange never pulses.
//  2. Pulse SecReq for 1 cycle at cycle 2.
//     -> ReqPending=1 next cycle.
//     -> StateFlag 0->1 at cycle 12 with PhaseChange pulse; 1->2 at 20; 2->3 at 28; 3->0 at 32.
//     -> ReqPending=0 from cycle 20.
//  3. Hold SecReq=1 throughout the SG phase.
//     -> Without SEC_EXTEND_EN: SG lasts 8 cycles; ReqPending re-sets on entry to SY.
//     -> With SEC_EXTEND_EN: SG lasts 16 cycles (T_SG_MAX), then SY.
//  4. Pulse SecReq on the same cycle SG is entered.
//     -> ReqPending stays 0 (clear wins).
//  5. Assert rst_n=0 mid-PY for 3 cycles.
//     -> StateFlag=0 and SecsLeft=3 asynchronously; restart matches scenario 1.
//  6. Tick-boundary check: SecReq rises on the cycle of a PG-resting tick.
//     -> Transition occurs at the following tick, not the same one.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the traffic phase controller and the maquete decoder.
//   Phase codes (StateFlag values):
//     PH_PG = 0 principal green, PH_PY = 1 principal yellow,
//     PH_SG = 2 secondary green, PH_SY = 3 secondary yellow.
//   PH_W  : width of the phase code.
//   TMR_W : width of the per-phase tick timer (SecsLeft).
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam int PH_W  = 2;
  localparam int TMR_W = 8;

  localparam logic [PH_W-1:0] PH_PG = 2'd0;
  localparam logic [PH_W-1:0] PH_PY = 2'd1;
  localparam logic [PH_W-1:0] PH_SG = 2'd2;
  localparam logic [PH_W-1:0] PH_SY = 2'd3;

  // FSM state type; encodings are the decoder phase codes, so the state
  // register drives StateFlag directly and every encoding is a legal phase.
  typedef enum logic [PH_W-1:0] {
    S_PG = PH_PG,
    S_PY = PH_PY,
    S_SG = PH_SG,
    S_SY = PH_SY
  } phase_e;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV cycles.
//   The count runs 0..TICK_DIV-1; tick is high while count == TICK_DIV-1,
//   after which the count wraps to 0. clr forces the count back to 0 so a
//   new phase always starts on a full tick period.
// Ports
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (count -> 0)
//   clr   in  synchronous restart of the count
//   tick  out one-cycle tick pulse
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
//   Sequences the phase code PG -> PY -> SG -> SY -> PG, timing each phase in
//   prescaler ticks. Principal green rests (SecsLeft held at 1) until a
//   secondary request has been latched; the switch then happens on a tick.
// Optional feature (macro SEC_EXTEND_EN):
//   Secondary green is held at its last tick while SecReq stays high, up to
//   T_SG_MAX elapsed SG ticks. Without the macro SG lasts exactly T_SG ticks
//   and neither the elapsed counter nor T_SG_MAX exists.
// Ports
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   SecReq      in  secondary detector level (already synchronised)
//   StateFlag   out current phase code (also the FSM state)
//   SecsLeft    out ticks remaining in the current phase
//   ReqPending  out latched secondary request
//   PhaseChange out one-cycle pulse in the first cycle of each new phase
// Handshake: none; SecReq is a level sampled every cycle, all outputs are
//   registered and change together on the same clk edge.
// -----------------------------------------------------------------------------
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
`ifdef SEC_EXTEND_EN
  parameter int T_SG_MAX = 20,
`endif
  parameter int T_PG_MIN = 20,
  parameter int T_PY     = 3,
  parameter int T_SG     = 10,
  parameter int T_SY     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SecReq,
  output logic [PH_W-1:0]  StateFlag,
  output logic [TMR_W-1:0] SecsLeft,
  output logic             ReqPending,
  output logic             PhaseChange
);

  phase_e             state_q, state_d, next_ph;
  logic [TMR_W-1:0]   secs_q, secs_d;
  logic               req_q, req_d;
  logic               pc_q, pc_d;
  logic               tick;
  logic               advance;
  logic               hold_sg;

  function automatic logic [TMR_W-1:0] phase_dur(input phase_e p);
    case (p)
      S_PG:    phase_dur = TMR_W'(T_PG_MIN);
      S_PY:    phase_dur = TMR_W'(T_PY);
      S_SG:    phase_dur = TMR_W'(T_SG);
      default: phase_dur = TMR_W'(T_SY);
    endcase
  endfunction

  // Restarting the prescaler on every phase change keeps each phase at
  // exactly duration*TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (advance),
    .tick (tick)
  );

`ifdef SEC_EXTEND_EN
  localparam logic [TMR_W:0] SG_MAX = (TMR_W + 1)'(T_SG_MAX);

  logic [TMR_W-1:0] elapsed_q, elapsed_d;

  // Hold only if the tick being taken now still leaves elapsed below the
  // ceiling; elapsed_q counts SG ticks already taken.
  assign hold_sg = SecReq && (({1'b0, elapsed_q} + 1'b1) < SG_MAX);

  always_comb begin
    elapsed_d = elapsed_q;
    if (advance && (next_ph == S_SG)) begin
      elapsed_d = '0;
    end else if (tick && (state_q == S_SG)) begin
      elapsed_d = elapsed_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end
`else
  assign hold_sg = 1'b0;
`endif

  always_comb begin
    next_ph = S_PG;
    case (state_q)
      S_PG:    next_ph = S_PY;
      S_PY:    next_ph = S_SG;
      S_SG:    next_ph = S_SY;
      default: next_ph = S_PG;
    endcase
  end

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    req_d   = req_q;
    advance = 1'b0;

    if (tick) begin
      if (secs_q > TMR_W'(1)) begin
        secs_d = secs_q - TMR_W'(1);
      end else begin
        // Last tick of the phase; SecsLeft stays at 1 if the phase rests.
        case (state_q)
          S_PG:    advance = req_q;
          S_SG:    advance = !hold_sg;
          default: advance = 1'b1;
        endcase
      end
    end

    if (advance) begin
      state_d = next_ph;
      secs_d  = phase_dur(next_ph);
    end

    // Entering SG clears the latch and wins over a same-cycle request.
    if (advance && (next_ph == S_SG)) begin
      req_d = 1'b0;
    end else if (SecReq && (state_q != S_SG)) begin
      req_d = 1'b1;
    end

    pc_d = advance;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PG;
      secs_q  <= TMR_W'(T_PG_MIN);
      req_q   <= 1'b0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
    end
  end

  assign StateFlag   = state_q;
  assign SecsLeft    = secs_q;
  assign ReqPending  = req_q;
  assign PhaseChange = pc_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_controller
//   Directed scenarios followed by random SecReq/reset traffic. A reference
//   model computes each cycle's outputs from phase start times and tick
//   arithmetic; expectations go into exp_q and a negedge monitor compares.
// -----------------------------------------------------------------------------
module tb_traffic_phase_controller;

  localparam int TICK_DIV = 4;
  localparam int T_PG_MIN = 3;
  localparam int T_PY     = 2;
  localparam int T_SG     = 2;
  localparam int T_SY     = 1;
  localparam int T_SG_MAX = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       SecReq;
  logic [1:0] StateFlag;
  logic [7:0] SecsLeft;
  logic       ReqPending;
  logic       PhaseChange;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .TICK_DIV(TICK_DIV),
`ifdef SEC_EXTEND_EN
    .T_SG_MAX(T_SG_MAX),
`endif
    .T_PG_MIN(T_PG_MIN),
    .T_PY    (T_PY),
    .T_SG    (T_SG),
    .T_SY    (T_SY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SecReq     (SecReq),
    .StateFlag  (StateFlag),
    .SecsLeft   (SecsLeft),
    .ReqPending (ReqPending),
    .PhaseChange(PhaseChange)
  );

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];   // {StateFlag, SecsLeft, ReqPending, PhaseChange}
  int          cyc_q[$];
  int          pc_log[$];  // cycles in which the DUT showed PhaseChange
  int          n_checks = 0;
  int          n_errors = 0;

  // ---------------- reference model ----------------
  int m_phase = 0;   // 0 PG, 1 PY, 2 SG, 3 SY
  int m_start = 0;   // first cycle of the current phase (counting cycle)
  int m_chg   = -1;  // cycle in which PhaseChange is expected
  int m_req   = 0;
  int cyc     = 0;

  function automatic int dur(input int p);
    case (p)
      0:       return T_PG_MIN;
      1:       return T_PY;
      2:       return T_SG;
      default: return T_SY;
    endcase
  endfunction

  // One clock cycle: apply inputs, record expected outputs, advance model.
  task automatic step(input logic req, input logic rstn);
    int el, k, secs, old;
    logic end_ph;
    logic [11:0] e;
    @(posedge clk);
    #1;
    if (!rstn && rst_n) begin
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (StateFlag !== 2'd0 || SecsLeft !== 8'(T_PG_MIN)) begin
        n_errors++;
        $display("FAIL async_reset: got sf=%0d secs=%0d, want sf=0 secs=%0d",
                 StateFlag, SecsLeft, T_PG_MIN);
      end
    end else begin
      rst_n = rstn;
    end
    SecReq = req;
    if (!rstn) begin
      e       = {2'd0, 8'(T_PG_MIN), 1'b0, 1'b0};
      m_phase = 0;
      m_start = cyc + 1;
      m_chg   = -1;
      m_req   = 0;
    end else begin
      el   = cyc - m_start;
      k    = el / TICK_DIV;
      secs = (k < dur(m_phase)) ? dur(m_phase) - k : 1;
      e    = {2'(m_phase), 8'(secs), 1'(m_req), (cyc == m_chg)};
      end_ph = 1'b0;
      if ((el % TICK_DIV) == TICK_DIV - 1 && k + 1 >= dur(m_phase)) begin
        case (m_phase)
          0: end_ph = (m_req != 0);
`ifdef SEC_EXTEND_EN
          2: end_ph = !(req && (k + 1 < T_SG_MAX));
`endif
          default: end_ph = 1'b1;
        endcase
      end
      old = m_phase;
      if (end_ph) begin
        m_phase = (m_phase + 1) % 4;
        m_start = cyc + 1;
        m_chg   = cyc + 1;
      end
      if (end_ph && m_phase == 2) m_req = 0;
      else if (req && old != 2) m_req = 1;
    end
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    cyc++;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [11:0] e;
    logic [11:0] got;
    int c;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        c   = cyc_q.pop_front();
        got = {StateFlag, SecsLeft, ReqPending, PhaseChange};
        n_checks++;
        if (got !== e) begin
          n_errors++;
          $display("FAIL outputs cycle %0d: got sf=%0d secs=%0d req=%0d pc=%0d, want sf=%0d secs=%0d req=%0d pc=%0d",
                   c, got[11:10], got[9:2], got[1], got[0], e[11:10], e[9:2], e[1], e[0]);
        end
        if (PhaseChange === 1'b1) pc_log.push_back(c);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  // ---------------- driver ----------------
  initial begin
    int rel;
    int guard;
    int want_pc[4];
    want_pc = '{12, 20, 28, 32};
    rst_n  = 1'b0;
    SecReq = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    // 1: idle principal green, rests at SecsLeft=1
    repeat (40) step(1'b0, 1'b1);

    // 2: single request pulse at cycle 2 after release
    repeat (2) step(1'b0, 1'b0);
    rel = cyc;
    pc_log.delete();
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (35) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    n_checks++;
    if (pc_log.size() != 4) begin
      n_errors++;
      $display("FAIL scen2_pc_count: got %0d phase changes, want 4", pc_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pc_log[i] - rel != want_pc[i]) begin
          n_errors++;
          $display("FAIL scen2_pc_cycle%0d: got cycle %0d, want %0d", i, pc_log[i] - rel, want_pc[i]);
        end
      end
    end

    // 3: SecReq held high across secondary green
    repeat (60) step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1);

    // 4: request pulse on the cycle secondary green is entered
    guard = 0;
    while (!(m_phase == 2 && m_chg == cyc) && guard < 300) begin
      step(($urandom_range(0, 3) == 0), 1'b1);
      guard++;
    end
    if (guard >= 300) timeout_fail("scen4_sg_entry");
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);

    // 5: reset asserted mid principal yellow
    guard = 0;
    while (!(m_phase == 1 && cyc > m_start) && guard < 300) begin
      step(1'b1, 1'b1);
      guard++;
    end
    if (guard >= 300) timeout_fail("scen5_py");
    repeat (3) step(1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1);

    // 6: request rises on a resting principal-green tick
    guard = 0;
    while (!(m_phase == 0 && m_req == 0 &&
             (cyc - m_start) / TICK_DIV >= T_PG_MIN - 1 &&
             (cyc - m_start) % TICK_DIV == TICK_DIV - 1) && guard < 300) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 300) timeout_fail("scen6_rest_tick");
    step(1'b1, 1'b1);
    repeat (12) step(1'b0, 1'b1);

    // random traffic with bursts and rare resets
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic rn;
      rn = ($urandom_range(0, 199) != 0);
      r  = (i % 200 < 60) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      step(r, rn);
    end
    step(1'b0, 1'b1);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
